// File: rtl/restador_serial.sv
// Bit-serial subtractor R = A - B (mod 2^WIDTH), LSB first, init/done handshake.
// Define RESTA_OVF_EN to build the signed-overflow flag; otherwise ovf is tied low.
module restador_serial #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] R,
    output logic             borrow,
    output logic             zero,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_br;
    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_br_next;
    logic             w_last;
    logic [WIDTH-1:0] w_sr_next;

    // 1-bit subtractor cell
    assign w_a       = r_sa[0];
    assign w_b       = r_sb[0];
    assign w_d       = w_a ^ w_b ^ r_br;
    assign w_br_next = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_sr_next = {w_d, r_sr[WIDTH-1:1]};
    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (init) w_next = S_LOAD;
            S_LOAD: begin
                busy   = 1'b1;
                w_next = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Results are latched on the edge entering DONE (using the final bit's
    // cell outputs) so R/borrow/zero are already valid while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sa   <= '0;
            r_sb   <= '0;
            r_sr   <= '0;
            r_cnt  <= '0;
            r_br   <= 1'b0;
            R      <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_sa  <= A;
                    r_sb  <= B;
                    r_sr  <= '0;
                    r_cnt <= '0;
                    r_br  <= 1'b0;
                end
                S_RUN: begin
                    r_sr  <= w_sr_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        R      <= w_sr_next;
                        borrow <= w_br_next;
                        zero   <= (w_sr_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RESTA_OVF_EN
    logic r_a_msb;
    logic r_b_msb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (r_state == S_LOAD) begin
                r_a_msb <= A[WIDTH-1];
                r_b_msb <= B[WIDTH-1];
            end
            if (r_state == S_RUN && w_last)
                ovf <= (r_a_msb != r_b_msb) && (w_sr_next[WIDTH-1] != r_a_msb);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Self-checking bench for restador_serial (WIDTH=4): vector table, random ops,
// mid-run init/operand changes and a mid-run reset.
module tb_restador_serial;
    localparam int W = 4;
`ifdef RESTA_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk  = 1'b0;
    logic         rst  = 1'b0;
    logic         init = 1'b0;
    logic [W-1:0] A    = '0;
    logic [W-1:0] B    = '0;
    logic [W-1:0] R;
    logic         borrow, zero, ovf, busy, done;

    always #5 clk = ~clk;

    restador_serial #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .init(init), .A(A), .B(B), .R(R),
        .borrow(borrow), .zero(zero), .ovf(ovf), .busy(busy), .done(done)
    );

    typedef struct { logic [3:0] a, b, r; logic br, z, ov; } vec_t;
    typedef struct { logic [3:0] r; logic br, z, ov; } exp_t;

    exp_t       sb_q[$];
    vec_t       tbl[9];
    int         errors = 0;
    int         checks = 0;
    logic [3:0] last_r = '0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.r  = a - b;
        e.br = (a < b);
        e.z  = (e.r == 4'd0);
        e.ov = OVF_ON && (a[3] != b[3]) && (e.r[3] != a[3]);
        return e;
    endfunction

    // Cycle 1 is the LOAD cycle right after the edge that samples init,
    // so done is expected in cycle W+2 with busy high for W+1 cycles.
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input exp_t e, input bit disturb);
        int   cyc, busy_n, pulses;
        exp_t x;
        @(negedge clk);
        A = a; B = b; init = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        init = 1'b0;
        cyc = 1; busy_n = 0;
        while (!done && cyc <= 20) begin
            if (busy) busy_n++;
            if (disturb && cyc == 3) begin
                chk("hold_R", R, last_r);
                init = 1'b1; A = ~a; B = ~b;
            end
            if (disturb && cyc == 5) init = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, W + 2);
        chk("busy_cycles", busy_n, W + 1);
        chk("busy_in_done", busy, 0);
        if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
        end else begin
            x = sb_q.pop_front();
            chk("R", R, x.r);
            chk("borrow", borrow, x.br);
            chk("zero", zero, x.z);
            chk("ovf", ovf, x.ov);
            last_r = x.r;
        end
        pulses = 0;
        repeat (W + 3) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("extra_done", pulses, 0);
        chk("R_hold_idle", R, last_r);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   pulses;
        logic [3:0] ra, rb;

        tbl[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b0, 1'b1};
        tbl[1] = '{4'd3,  4'd9,  4'hA,  1'b1, 1'b0, 1'b1};
        tbl[2] = '{4'd5,  4'd5,  4'd0,  1'b0, 1'b1, 1'b0};
        tbl[3] = '{4'd0,  4'hF,  4'd1,  1'b1, 1'b0, 1'b0};
        tbl[4] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b0, 1'b1};
        tbl[5] = '{4'hF,  4'd1,  4'hE,  1'b0, 1'b0, 1'b0};
        tbl[6] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b1, 1'b0};
        tbl[7] = '{4'd7,  4'd8,  4'hF,  1'b1, 1'b0, 1'b1};
        tbl[8] = '{4'd1,  4'd2,  4'hF,  1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_R", R, 0);
        chk("rst_borrow", borrow, 0);
        chk("rst_zero", zero, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk) rst = 1'b1;

        for (int i = 0; i < 9; i++) begin
            e.r  = tbl[i].r;
            e.br = tbl[i].br;
            e.z  = tbl[i].z;
            e.ov = OVF_ON ? tbl[i].ov : 1'b0;
            run_op(tbl[i].a, tbl[i].b, e, 1'b0);
        end

        for (int i = 0; i < 8; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            run_op(ra, rb, model(ra, rb), 1'b0);
        end

        // init re-asserted and operands changed mid-run must be ignored
        run_op(4'd9, 4'd3, model(4'd9, 4'd3), 1'b1);

        // reset during the 3rd RUN cycle of a new operation
        @(negedge clk);
        A = 4'd9; B = 4'd3; init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("mid_rst_R", R, 0);
        chk("mid_rst_borrow", borrow, 0);
        chk("mid_rst_zero", zero, 0);
        chk("mid_rst_ovf", ovf, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        chk("post_rst_idle", pulses, 0);
        last_r = 4'd0;
        run_op(4'd2, 4'd1, model(4'd2, 4'd1), 1'b0);

        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
